alu_pipe: RTL

- Parametrised, registered successor to the processor's combinational ALU, used in the EX stage of the pipelined core.
- Keeps the existing ALUControl encodings for ADD/SUB/OR/AND/XOR. Adds shifts, set-less-than, and an iterative multi-cycle multiply.
- Adds a full N/Z/C/V flag set that is defined for every op.
- Valid/ready handshakes on input and output let the hazard unit stall on multiply.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_mul_iter.sv | 65 ++++++
 rtl/alu_pipe.sv | 118 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALUControl codes, FSM states and flag-nibble layout for alu_pipe
package alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_MUL  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1100;
  typedef enum logic {IDLE = 1'b0, MUL_RUN = 1'b1} state_t;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
  function automatic logic [3:0] pack_flags(input logic z, input logic n, input logic c, input logic v);
    logic [3:0] f;
    f = '0;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: fixed-latency shift-add multiplier, one partial product per cycle for WIDTH cycles
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             run,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CW-1:0] count_q, count_d;
  logic lost_q, lost_d, ovf_q, ovf_d;
  logic [WIDTH:0] sum;
  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, mcand_q};
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    count_d = count_q;
    lost_d = lost_q;
    ovf_d = ovf_q;
    if (start) begin
      mcand_d = a;
      mplier_d = b;
      acc_d = '0;
      count_d = '0;
      lost_d = 1'b0;
      ovf_d = 1'b0;
    end else if (run) begin
      // lost_q: multiplicand bits already shifted past WIDTH; adding them would overflow
      acc_d = mplier_q[0] ? sum[WIDTH-1:0] : acc_q;
      ovf_d = ovf_q | (mplier_q[0] & (sum[WIDTH] | lost_q));
      lost_d = lost_q | mcand_q[WIDTH-1];
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d = count_q + CW'(1);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      count_q <= '0;
      lost_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      count_q <= count_d;
      lost_q <= lost_d;
      ovf_q <= ovf_d;
    end
  end
  assign done = run && count_q == CW'(WIDTH - 1);
  assign product = acc_d;
  assign ovf = ovf_d;
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered EX-stage ALU with N/Z/C/V flags, valid/ready handshakes and iterative multiply
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             illegal_op
);
  state_t state_q, state_d;
  logic out_valid_q, out_valid_d, illegal_q, illegal_d;
  logic [WIDTH-1:0] result_q, result_d, alu_res, mul_prod;
  logic [3:0] flags_q, flags_d;
  logic accept, mul_start, mul_done, mul_ovf, alu_c, alu_v, alu_ill;
  logic [WIDTH:0] add_s, sub_s, sll_w, srl_w, sra_w;
  logic [SHW-1:0] sh;
  assign in_ready = state_q == IDLE && (!out_valid_q || out_ready);
  assign accept = in_valid && in_ready;
  assign mul_start = accept && op == ALU_MUL;
  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .reset(reset), .start(mul_start), .run(state_q == MUL_RUN),
    .a(a), .b(b), .done(mul_done), .product(mul_prod), .ovf(mul_ovf)
  );
  always_comb begin
    sh = b[SHW-1:0];
    add_s = {1'b0, a} + {1'b0, b};
    sub_s = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    // a zero guard bit beside the operand catches the last bit shifted out
    sll_w = {1'b0, a} << sh;
    srl_w = {a, 1'b0} >> sh;
    sra_w = $signed({a, 1'b0}) >>> sh;
    alu_res = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    alu_ill = 1'b0;
    case (op)
      ALU_ADD: begin
        alu_res = add_s[WIDTH-1:0];
        alu_c = add_s[WIDTH];
        alu_v = a[WIDTH-1] == b[WIDTH-1] && alu_res[WIDTH-1] != a[WIDTH-1];
      end
      ALU_SUB: begin
        alu_res = sub_s[WIDTH-1:0];
        alu_c = sub_s[WIDTH];
        alu_v = a[WIDTH-1] != b[WIDTH-1] && alu_res[WIDTH-1] != a[WIDTH-1];
      end
      ALU_OR:   alu_res = a | b;
      ALU_AND:  alu_res = a & b;
      ALU_XOR:  alu_res = a ^ b;
      ALU_SLL:  {alu_c, alu_res} = sll_w;
      ALU_SRL:  {alu_res, alu_c} = srl_w;
      ALU_SRA:  {alu_res, alu_c} = sra_w;
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      ALU_MUL:  alu_res = '0;
      default:  alu_ill = 1'b1;
    endcase
  end
  always_comb begin
    state_d = state_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d = result_q;
    flags_d = flags_q;
    illegal_d = illegal_q;
    if (mul_done) begin
      state_d = IDLE;
      out_valid_d = 1'b1;
      result_d = mul_prod;
      flags_d = pack_flags(mul_prod == '0, mul_prod[WIDTH-1], 1'b0, mul_ovf);
      illegal_d = 1'b0;
    end else if (mul_start) begin
      state_d = MUL_RUN;
    end else if (accept) begin
      out_valid_d = 1'b1;
      result_d = alu_res;
      flags_d = pack_flags(alu_res == '0, alu_res[WIDTH-1], alu_c, alu_v);
      illegal_d = alu_ill;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      out_valid_q <= 1'b0;
      result_q <= '0;
      flags_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_valid_q <= out_valid_d;
      result_q <= result_d;
      flags_q <= flags_d;
      illegal_q <= illegal_d;
    end
  end
  // a multiply is only accepted once the output slot is free, so it can never finish into a stalled result
  assert property (@(posedge clk) disable iff (reset) !(mul_done && out_valid_q && !out_ready));
  assign out_valid = out_valid_q;
  assign result = result_q;
  assign flag_z = flags_q[FLAG_Z];
  assign flag_n = flags_q[FLAG_N];
  assign flag_c = flags_q[FLAG_C];
  assign flag_v = flags_q[FLAG_V];
  assign illegal_op = illegal_q;
endmodule
